// File: rtl/i3c_ccc_bcast_ctrl_pkg.sv
// Shared CCC codes, event-enable bit positions, FSM and decode types for the broadcast CCC sequencer.
// SETMRL support is selected in the top and decoder with I3C_CCC_SETMRL_EN.
package i3c_pkg;

  localparam logic [7:0] CCC_ENEC       = 8'h00;
  localparam logic [7:0] CCC_DISEC      = 8'h01;
  localparam logic [7:0] CCC_RSTDAA     = 8'h06;
  localparam logic [7:0] CCC_ENTDAA     = 8'h07;
  localparam logic [7:0] CCC_SETMWL     = 8'h09;
  localparam logic [7:0] CCC_SETMRL     = 8'h0A;
  localparam logic [7:0] CCC_DIRECT_MIN = 8'h80;

  localparam int EVT_INT = 0;
  localparam int EVT_CR  = 1;
  localparam int EVT_HJ  = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_COLLECT   = 3'd2,
    ST_APPLY     = 3'd3,
    ST_ENTDAA    = 3'd4,
    ST_WAIT_STOP = 3'd5,
    ST_DISCARD   = 3'd6
  } ccc_state_e;

  typedef enum logic [2:0] {
    K_ENEC   = 3'd0,
    K_DISEC  = 3'd1,
    K_RSTDAA = 3'd2,
    K_ENTDAA = 3'd3,
    K_SETMWL = 3'd4,
    K_SETMRL = 3'd5,
    K_DIRECT = 3'd6,
    K_UNSUP  = 3'd7
  } ccc_kind_e;

  // len is the payload byte count that completes the CCC (SETMRL: the 3-byte form).
  typedef struct packed {
    logic [1:0] len;
    ccc_kind_e  kind;
    logic       supported;
  } ccc_info_t;

endpackage

// File: rtl/i3c_ccc_bcast_ctrl_if.sv
// Handshake bundle between the SDR broadcast byte receiver (master) and the CCC sequencer (slave).
// All receiver strobes are single-cycle pulses; there is no backpressure path.
interface i3c_ccc_bcast_ctrl_if;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        data_valid;
  logic [7:0]  data_byte;
  logic        parity_err;
  logic        start_detect;
  logic        stop_detected;
  logic        ibi_en;
  logic        cr_en;
  logic        hj_en;
  logic [15:0] mwl;
  logic [15:0] mrl;
  logic [7:0]  ibi_len;
  logic        rstdaa_pulse;
  logic        entdaa_req;
  logic        direct_pending;
  logic        ccc_err;

  modport master (
    output cmd_valid, cmd_byte, data_valid, data_byte, parity_err, start_detect, stop_detected,
    input  ibi_en, cr_en, hj_en, mwl, mrl, ibi_len, rstdaa_pulse, entdaa_req, direct_pending, ccc_err
  );

  modport slave (
    input  cmd_valid, cmd_byte, data_valid, data_byte, parity_err, start_detect, stop_detected,
    output ibi_en, cr_en, hj_en, mwl, mrl, ibi_len, rstdaa_pulse, entdaa_req, direct_pending, ccc_err
  );
endinterface

// File: rtl/i3c_ccc_bcast_ctrl_decode.sv
// Combinational CCC code decoder: payload length, kind and supported flag; zero latency.
// SETMRL decodes as supported only when I3C_CCC_SETMRL_EN is defined.
module i3c_ccc_decode
  import i3c_pkg::*;
(
  input  logic [7:0] code_i,
  output ccc_info_t  info_o
);

  always_comb begin
    info_o = '{len: 2'd0, kind: K_UNSUP, supported: 1'b0};
    if (code_i >= CCC_DIRECT_MIN) begin
      info_o.kind = K_DIRECT;
    end else begin
      case (code_i)
        CCC_ENEC:   info_o = '{len: 2'd1, kind: K_ENEC,   supported: 1'b1};
        CCC_DISEC:  info_o = '{len: 2'd1, kind: K_DISEC,  supported: 1'b1};
        CCC_RSTDAA: info_o = '{len: 2'd0, kind: K_RSTDAA, supported: 1'b1};
        CCC_ENTDAA: info_o = '{len: 2'd0, kind: K_ENTDAA, supported: 1'b1};
        CCC_SETMWL: info_o = '{len: 2'd2, kind: K_SETMWL, supported: 1'b1};
`ifdef I3C_CCC_SETMRL_EN
        CCC_SETMRL: info_o = '{len: 2'd3, kind: K_SETMRL, supported: 1'b1};
`endif
        default:    info_o = '{len: 2'd0, kind: K_UNSUP,  supported: 1'b0};
      endcase
    end
  end

endmodule

// File: rtl/i3c_ccc_bcast_ctrl.sv
// Broadcast CCC sequencer: decode, collect payload, commit enables/lengths atomically one cycle after APPLY.
// No backpressure (inputs are pulses); optional SETMRL support via I3C_CCC_SETMRL_EN.
module i3c_ccc_bcast_ctrl
  import i3c_pkg::*;
#(
  parameter logic [15:0] MWL_RESET     = 16'd64,
  parameter logic [15:0] MRL_RESET     = 16'd64,
  parameter logic [7:0]  IBI_LEN_RESET = 8'd0
) (
  input  logic                clk,
  input  logic                rst,
  i3c_ccc_bcast_ctrl_if.slave bus
);

`ifdef I3C_CCC_SETMRL_EN
  localparam int HOLD_W = 24;
`else
  localparam int HOLD_W = 16;
`endif

  ccc_state_e        state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        cnt_q, cnt_d, cnt_inc;
  logic              stop_seen_q, stop_seen_d;
  logic              ibi_en_q, ibi_en_d, cr_en_q, cr_en_d, hj_en_q, hj_en_d;
  logic [15:0]       mwl_q, mwl_d;
  logic              rstdaa_q, rstdaa_d, entdaa_q, entdaa_d;
  logic              direct_q, direct_d, direct_set, err_q, err_d;
`ifdef I3C_CCC_SETMRL_EN
  logic [15:0]       mrl_q, mrl_d;
  logic [7:0]        ibi_len_q, ibi_len_d;
`endif

  ccc_info_t info;

  i3c_ccc_decode u_decode (
    .code_i (cmd_q),
    .info_o (info)
  );

  assign cnt_inc = cnt_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    stop_seen_d = stop_seen_q;
    ibi_en_d    = ibi_en_q;
    cr_en_d     = cr_en_q;
    hj_en_d     = hj_en_q;
    mwl_d       = mwl_q;
`ifdef I3C_CCC_SETMRL_EN
    mrl_d       = mrl_q;
    ibi_len_d   = ibi_len_q;
`endif
    err_d       = 1'b0;
    direct_set  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = ST_DECODE;
          cmd_d   = bus.cmd_byte;
        end
      end
      ST_DECODE: begin
        hold_d      = '0;
        cnt_d       = 2'd0;
        stop_seen_d = 1'b0;
        if (bus.start_detect) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.parity_err) begin
          err_d   = 1'b1;
          state_d = ST_DISCARD;
        end else if (bus.stop_detected) begin
          err_d   = (info.kind != K_DIRECT);
          state_d = ST_IDLE;
        end else if (info.kind == K_DIRECT) begin
          direct_set = 1'b1;
          state_d    = ST_DISCARD;
        end else if (!info.supported) begin
          err_d   = 1'b1;
          state_d = ST_DISCARD;
        end else if (info.len == 2'd0) begin
          state_d = ST_APPLY;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bus.start_detect) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.parity_err) begin
          err_d   = 1'b1;
          state_d = ST_DISCARD;
        end else if (bus.stop_detected) begin
          // The short 2-byte SETMRL form is still a complete command.
          if (info.kind == K_SETMRL && cnt_q == 2'd2) begin
            stop_seen_d = 1'b1;
            state_d     = ST_APPLY;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (bus.data_valid) begin
          hold_d = {hold_q[HOLD_W-9:0], bus.data_byte};
          cnt_d  = cnt_inc;
          if (cnt_inc == info.len) begin
            state_d = ST_APPLY;
          end
        end
      end
      ST_APPLY: begin
        case (info.kind)
          K_ENEC: begin
            if (hold_q[EVT_INT]) ibi_en_d = 1'b1;
            if (hold_q[EVT_CR])  cr_en_d  = 1'b1;
            if (hold_q[EVT_HJ])  hj_en_d  = 1'b1;
          end
          K_DISEC: begin
            if (hold_q[EVT_INT]) ibi_en_d = 1'b0;
            if (hold_q[EVT_CR])  cr_en_d  = 1'b0;
            if (hold_q[EVT_HJ])  hj_en_d  = 1'b0;
          end
          K_SETMWL: mwl_d = hold_q[15:0];
`ifdef I3C_CCC_SETMRL_EN
          K_SETMRL: begin
            if (cnt_q == 2'd3) begin
              mrl_d     = hold_q[23:8];
              ibi_len_d = hold_q[7:0];
            end else begin
              mrl_d = hold_q[15:0];
            end
          end
`endif
          default: ;
        endcase
        if (stop_seen_q || bus.stop_detected) begin
          state_d = ST_IDLE;
        end else if (info.kind == K_ENTDAA) begin
          state_d = ST_ENTDAA;
        end else begin
          state_d = ST_WAIT_STOP;
        end
      end
      ST_ENTDAA, ST_WAIT_STOP, ST_DISCARD: begin
        if (bus.stop_detected) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rstdaa_d = (state_d == ST_APPLY) && (info.kind == K_RSTDAA);
    entdaa_d = ((state_d == ST_APPLY) || (state_d == ST_ENTDAA)) && (info.kind == K_ENTDAA);
    direct_d = (state_d == ST_DISCARD) && (direct_set || direct_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'h00;
      hold_q      <= '0;
      cnt_q       <= 2'd0;
      stop_seen_q <= 1'b0;
      ibi_en_q    <= 1'b1;
      cr_en_q     <= 1'b1;
      hj_en_q     <= 1'b1;
      mwl_q       <= MWL_RESET;
      rstdaa_q    <= 1'b0;
      entdaa_q    <= 1'b0;
      direct_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef I3C_CCC_SETMRL_EN
      mrl_q       <= MRL_RESET;
      ibi_len_q   <= IBI_LEN_RESET;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      stop_seen_q <= stop_seen_d;
      ibi_en_q    <= ibi_en_d;
      cr_en_q     <= cr_en_d;
      hj_en_q     <= hj_en_d;
      mwl_q       <= mwl_d;
      rstdaa_q    <= rstdaa_d;
      entdaa_q    <= entdaa_d;
      direct_q    <= direct_d;
      err_q       <= err_d;
`ifdef I3C_CCC_SETMRL_EN
      mrl_q       <= mrl_d;
      ibi_len_q   <= ibi_len_d;
`endif
    end
  end

  assign bus.ibi_en         = ibi_en_q;
  assign bus.cr_en          = cr_en_q;
  assign bus.hj_en          = hj_en_q;
  assign bus.mwl            = mwl_q;
  assign bus.rstdaa_pulse   = rstdaa_q;
  assign bus.entdaa_req     = entdaa_q;
  assign bus.direct_pending = direct_q;
  assign bus.ccc_err        = err_q;
`ifdef I3C_CCC_SETMRL_EN
  assign bus.mrl            = mrl_q;
  assign bus.ibi_len        = ibi_len_q;
`else
  assign bus.mrl            = MRL_RESET;
  assign bus.ibi_len        = IBI_LEN_RESET;
`endif

endmodule

// File: tb/tb_i3c_ccc_bcast_ctrl.sv
// Directed bench for the broadcast CCC sequencer: register results go through an expectation queue,
// pulse timing is checked cycle by cycle. Honours I3C_CCC_SETMRL_EN for the SETMRL cases.
module tb_i3c_ccc_bcast_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i3c_ccc_bcast_ctrl_if bus ();

  i3c_ccc_bcast_ctrl #(
    .MWL_RESET     (16'd64),
    .MRL_RESET     (16'd64),
    .IBI_LEN_RESET (8'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic        ibi, cr, hj;
    logic [15:0] mwl, mrl;
    logic [7:0]  ibi_len;
    int          errs;
  } exp_t;

  exp_t sb[$];

  logic        m_ibi, m_cr, m_hj;
  logic [15:0] m_mwl, m_mrl;
  logic [7:0]  m_ibi_len;

  int n_cmp = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int rst_cnt = 0;
  int err_base = 0;

  always @(negedge clk) begin
    if (bus.ccc_err === 1'b1) err_cnt++;
    if (bus.rstdaa_pulse === 1'b1) rst_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ibi = 1'b1; m_cr = 1'b1; m_hj = 1'b1;
    m_mwl = 16'd64; m_mrl = 16'd64; m_ibi_len = 8'd0;
  endtask

  task automatic push_exp(input string tag, input int errs);
    exp_t e;
    e.tag = tag; e.ibi = m_ibi; e.cr = m_cr; e.hj = m_hj;
    e.mwl = m_mwl; e.mrl = m_mrl; e.ibi_len = m_ibi_len; e.errs = errs;
    sb.push_back(e);
    err_base = err_cnt;
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".ibi_en"}, 32'(bus.ibi_en), 32'(e.ibi));
      chk({e.tag, ".cr_en"}, 32'(bus.cr_en), 32'(e.cr));
      chk({e.tag, ".hj_en"}, 32'(bus.hj_en), 32'(e.hj));
      chk({e.tag, ".mwl"}, 32'(bus.mwl), 32'(e.mwl));
      chk({e.tag, ".mrl"}, 32'(bus.mrl), 32'(e.mrl));
      chk({e.tag, ".ibi_len"}, 32'(bus.ibi_len), 32'(e.ibi_len));
      chk({e.tag, ".err_pulses"}, 32'(err_cnt - err_base), 32'(e.errs));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] code);
    bus.cmd_valid = 1'b1; bus.cmd_byte = code;
    idle(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    bus.data_valid = 1'b1; bus.data_byte = b;
    idle(1);
    bus.data_valid = 1'b0;
  endtask

  task automatic send_stop();
    bus.stop_detected = 1'b1;
    idle(1);
    bus.stop_detected = 1'b0;
  endtask

  task automatic send_parity();
    bus.parity_err = 1'b1;
    idle(1);
    bus.parity_err = 1'b0;
  endtask

  // Complete CCC with up to three payload bytes, then STOP and settle.
  task automatic run_ccc(input logic [7:0] code, input int n, input logic [23:0] bytes);
    send_cmd(code);
    idle(2);
    for (int i = 0; i < n; i++) begin
      send_data(bytes[23 - 8*i -: 8]);
      idle(1);
    end
    send_stop();
    idle(2);
  endtask

  initial begin
    int rb;
    logic [15:0] old_mwl;
    bus.cmd_valid = 1'b0; bus.cmd_byte = 8'h00;
    bus.data_valid = 1'b0; bus.data_byte = 8'h00;
    bus.parity_err = 1'b0; bus.start_detect = 1'b0; bus.stop_detected = 1'b0;
    rst = 1'b1;
    model_reset();
    idle(3);
    rst = 1'b0;

    push_exp("reset", 0);
    check_sb();
    chk("reset.rstdaa", 32'(bus.rstdaa_pulse), 32'd0);
    chk("reset.entdaa", 32'(bus.entdaa_req), 32'd0);
    chk("reset.direct", 32'(bus.direct_pending), 32'd0);
    chk("reset.ccc_err", 32'(bus.ccc_err), 32'd0);

    push_exp("enec_00", 0);
    run_ccc(8'h00, 1, 24'h000000);
    check_sb();

    m_ibi = 1'b0; m_hj = 1'b0;
    push_exp("disec_09", 0);
    run_ccc(8'h01, 1, 24'h090000);
    check_sb();

    m_ibi = 1'b1;
    push_exp("enec_01", 0);
    run_ccc(8'h00, 1, 24'h010000);
    check_sb();

    push_exp("setmwl_short", 1);
    run_ccc(8'h09, 1, 24'h020000);
    check_sb();

    push_exp("setmwl_stop_wins", 1);
    send_cmd(8'h09);
    idle(2);
    send_data(8'h55);
    bus.data_valid = 1'b1; bus.data_byte = 8'hAA; bus.stop_detected = 1'b1;
    idle(1);
    bus.data_valid = 1'b0; bus.stop_detected = 1'b0;
    idle(2);
    check_sb();

    old_mwl = m_mwl;
    m_mwl = 16'h0100;
    push_exp("setmwl_full", 0);
    send_cmd(8'h09);
    idle(2);
    send_data(8'h01);
    idle(1);
    send_data(8'h00);
    chk("setmwl.apply_cycle_old", 32'(bus.mwl), 32'(old_mwl));
    idle(1);
    chk("setmwl.committed", 32'(bus.mwl), 32'h0100);
    send_stop();
    idle(2);
    check_sb();

    push_exp("rstdaa", 0);
    rb = rst_cnt;
    send_cmd(8'h06);
    chk("rstdaa.decode_cycle", 32'(bus.rstdaa_pulse), 32'd0);
    idle(1);
    chk("rstdaa.apply_cycle", 32'(bus.rstdaa_pulse), 32'd1);
    idle(1);
    chk("rstdaa.after", 32'(bus.rstdaa_pulse), 32'd0);
    send_stop();
    idle(2);
    chk("rstdaa.pulse_count", 32'(rst_cnt - rb), 32'd1);
    check_sb();

    push_exp("entdaa", 0);
    send_cmd(8'h07);
    chk("entdaa.decode_cycle", 32'(bus.entdaa_req), 32'd0);
    idle(1);
    chk("entdaa.rise", 32'(bus.entdaa_req), 32'd1);
    idle(4);
    chk("entdaa.held", 32'(bus.entdaa_req), 32'd1);
    send_stop();
    chk("entdaa.fall", 32'(bus.entdaa_req), 32'd0);
    idle(2);
    check_sb();

    push_exp("direct_8a", 0);
    rb = rst_cnt;
    send_cmd(8'h8A);
    chk("direct.decode_cycle", 32'(bus.direct_pending), 32'd0);
    idle(1);
    chk("direct.set", 32'(bus.direct_pending), 32'd1);
    send_cmd(8'h06);
    send_data(8'h33);
    idle(3);
    chk("direct.held", 32'(bus.direct_pending), 32'd1);
    send_stop();
    chk("direct.cleared", 32'(bus.direct_pending), 32'd0);
    idle(4);
    chk("direct.cmd_ignored", 32'(rst_cnt - rb), 32'd0);
    check_sb();

    push_exp("unsup_2f", 1);
    send_cmd(8'h2F);
    chk("unsup.decode_cycle", 32'(bus.ccc_err), 32'd0);
    idle(1);
    chk("unsup.err_pulse", 32'(bus.ccc_err), 32'd1);
    idle(1);
    chk("unsup.err_drop", 32'(bus.ccc_err), 32'd0);
    chk("unsup.no_direct", 32'(bus.direct_pending), 32'd0);
    send_stop();
    idle(2);
    check_sb();

`ifdef I3C_CCC_SETMRL_EN
    m_mrl = 16'h0080; m_ibi_len = 8'h10;
    push_exp("setmrl_3b", 0);
`else
    push_exp("setmrl_3b", 1);
`endif
    run_ccc(8'h0A, 3, 24'h008010);
    check_sb();

`ifdef I3C_CCC_SETMRL_EN
    m_mrl = 16'h0100;
    push_exp("setmrl_2b", 0);
`else
    push_exp("setmrl_2b", 1);
`endif
    run_ccc(8'h0A, 2, 24'h010000);
    check_sb();

    push_exp("setmwl_parity", 1);
    send_cmd(8'h09);
    idle(2);
    send_parity();
    idle(1);
    send_data(8'h12);
    idle(1);
    send_data(8'h34);
    idle(1);
    send_stop();
    idle(2);
    check_sb();

    m_ibi = 1'b0; m_cr = 1'b0; m_hj = 1'b0;
    push_exp("disec_0b", 0);
    run_ccc(8'h01, 1, 24'h0B0000);
    check_sb();

    model_reset();
    push_exp("reset_mid_ccc", 0);
    send_cmd(8'h09);
    idle(2);
    send_data(8'h77);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst.entdaa", 32'(bus.entdaa_req), 32'd0);
    check_sb();
    send_data(8'h88);
    idle(2);
    chk("midrst.partial_lost", 32'(bus.mwl), 32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i3c_ccc_bcast_ctrl.md
# i3c_ccc_bcast_ctrl

Target-side sequencer for broadcast Common Command Codes (CCCs). It sits downstream of the SDR broadcast byte receiver and consumes the captured command byte and any following data bytes. It decodes the CCC, collects the payload, and commits results to the target's event-enable and length registers, or raises control pulses. Direct CCCs and unsupported codes are parked until the bus STOP.

## Interface
- `MWL_RESET`, 16'd64: max write length after reset.
- `MRL_RESET`, 16'd64: max read length after reset.
- `IBI_LEN_RESET`, 8'd0: max IBI payload after reset.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: one-cycle pulse; broadcast command byte captured after 7'h7E+W.
- `cmd_byte` in 8: CCC code, valid with `cmd_valid`.
- `data_valid` in 1: one-cycle pulse per received data byte, T-bit already checked.
- `data_byte` in 8: payload byte, valid with `data_valid`.
- `parity_err` in 1: one-cycle pulse; T-bit mismatch on the current byte.
- `start_detect` in 1: (repeated) START seen.
- `stop_detected` in 1: STOP seen.
- `ibi_en`, `cr_en`, `hj_en` out 1 each: event enables.
- `mwl` out 16: committed max write length.
- `mrl` out 16: committed max read length.
- `ibi_len` out 8: committed max IBI payload length.
- `rstdaa_pulse` out 1: one-cycle pulse; clear the dynamic address.
- `entdaa_req` out 1: level; ENTDAA in progress.
- `direct_pending` out 1: level; a direct CCC (code ≥ 8'h80) awaits handling.
- `ccc_err` out 1: one-cycle pulse; aborted or unsupported CCC.

## Operation
- Supported codes:
  - ENEC 8'h00, 1 byte: set enables where the byte has bit0 (ENINT), bit1 (ENCR) or bit3 (ENHJ) = 1.
  - DISEC 8'h01, 1 byte: clear the same bits.
  - RSTDAA 8'h06, 0 bytes.
  - ENTDAA 8'h07, 0 bytes.
  - SETMWL 8'h09, 2 bytes, MSB first.
  - SETMRL 8'h0A, 2 or 3 bytes (see Configuration).
- FSM states and transitions:
  - IDLE: `cmd_valid` → DECODE.
  - DECODE (1 cycle):
    - 0-byte code → APPLY.
    - Byte-carrying code → COLLECT, byte counter cleared.
    - Code ≥ 8'h80 → DISCARD with `direct_pending`=1.
    - Other unsupported codes → DISCARD, `ccc_err` pulse.
  - COLLECT: each `data_valid` shifts the byte into a 24-bit holding register and increments a 2-bit counter. On reaching the required count → APPLY.
  - APPLY (1 cycle): commit registers or raise the pulse, then → WAIT_STOP. ENTDAA instead → ENTDAA state.
  - ENTDAA: `entdaa_req`=1 until `stop_detected`.
  - WAIT_STOP: extra data bytes are ignored. `stop_detected` → IDLE.
  - DISCARD: `stop_detected` → IDLE, and `direct_pending` clears.
- Abort conditions:
  - `parity_err`, or `start_detect`, in DECODE or COLLECT: no register change, `ccc_err` pulse, → DISCARD (parity) or IDLE (start).
  - `stop_detected` in COLLECT with a short payload: no commit, `ccc_err` pulse, → IDLE.
- Commits are atomic: a multi-byte register never holds a partial value.
- `stop_detected` has priority over `data_valid` in the same cycle. The byte is dropped.
- `cmd_valid` outside IDLE is ignored.

## Timing
- Reset values:
  - `ibi_en`=`cr_en`=`hj_en`=1.
  - `mwl`=MWL_RESET, `mrl`=MRL_RESET, `ibi_len`=IBI_LEN_RESET.
  - All pulses and levels 0. State IDLE.
- `rstdaa_pulse` asserts exactly 2 cycles after `cmd_valid` (DECODE, then APPLY), for 1 cycle.
- Register outputs update on the clock edge 1 cycle after the final `data_valid` (registered in the COLLECT→APPLY transition, visible from APPLY+1).
- `entdaa_req` rises 2 cycles after `cmd_valid` and falls the cycle after `stop_detected`.
- `ccc_err` is a 1-cycle pulse, registered.
- Reset asserted mid-CCC returns every output to its reset value on the next edge. Partial payloads are lost.

## Configuration
- `I3C_CCC_SETMRL_EN` defined:
  - SETMRL is supported.
  - A STOP after 2 bytes commits `mrl` only.
  - A third byte commits `mrl` and `ibi_len` together.
- `I3C_CCC_SETMRL_EN` undefined:
  - 8'h0A is unsupported (DISCARD + `ccc_err`).
  - `mrl` and `ibi_len` are constants at their reset values.

## Structure
- Shared package `i3c_pkg`:
  - CCC code localparams (CCC_ENEC, CCC_DISEC, CCC_RSTDAA, CCC_ENTDAA, CCC_SETMWL, CCC_SETMRL).
  - Event bit positions (EVT_INT=0, EVT_CR=1, EVT_HJ=3).
  - FSM state encoding.
- Sub-module `i3c_ccc_decode`: combinational code → {payload length, kind, supported}.

## Test plan
- Reset, then ENEC with byte 8'h00: all enables stay 1. DISEC with 8'h09: `ibi_en`=0, `hj_en`=0, `cr_en`=1. ENEC with 8'h01: `ibi_en`=1.
- SETMWL with bytes 8'h01, 8'h00, STOP: `mwl`=16'h0100, one cycle after the second byte. No `ccc_err`.
- SETMWL with byte 8'h02, then STOP: `mwl` unchanged at 64, one `ccc_err` pulse.
- RSTDAA: `rstdaa_pulse` high exactly 1 cycle, 2 cycles after `cmd_valid`.
- ENTDAA: `entdaa_req` high until STOP.
- Code 8'h8A: `direct_pending`=1 until STOP, no `ccc_err`.
- Code 8'h2F: `ccc_err` pulse, no register change.
- SETMRL with 8'h00, 8'h80, 8'h10: with the macro, `mrl`=16'h0080 and `ibi_len`=8'h10. Without the macro, both unchanged and a `ccc_err` pulse.
- `parity_err` on the first SETMWL byte: no change, `ccc_err` pulse. Bytes that follow before STOP are ignored.
